// File: rtl/fpu_accumulator_if.sv
// Product/result bus between the FP multiplier, the accumulator and its consumer.
// The master drives products and clear; the slave is the accumulator.
interface fpu_accumulator_if;
   logic        clear;
   logic [31:0] in_z;
   logic        in_z_stb;
   logic        in_ready;
   logic [31:0] acc_out;
   logic        acc_out_stb;
   logic        busy;
   logic        ovf_err;

   modport master (
      output clear, in_z, in_z_stb,
      input  in_ready, acc_out, acc_out_stb, busy, ovf_err
   );

   modport slave (
      input  clear, in_z, in_z_stb,
      output in_ready, acc_out, acc_out_stb, busy, ovf_err
   );
endinterface

// File: rtl/fpu_accumulator.sv
// Multi-cycle binary32 accumulator: sums K_LEN products (RNE) and emits the dot product.
// Define FPACC_FTZ_EN to flush denormal inputs and results to signed zero.
module fpu_accumulator #(
   parameter int K_LEN = 4,
   parameter int CNT_W = 8
) (
   input logic               clk,
   input logic               rst,
   fpu_accumulator_if.slave  bus
);

   typedef enum logic [3:0] {
      IDLE, UNPACK, SPECIAL, ALIGN, ADD, NORM_1, NORM_2, ROUND, PACK, COMMIT
   } state_t;

   localparam logic signed [9:0] EMIN = -10'sd126;
   localparam logic signed [9:0] EMAX = 10'sd127;
   localparam logic [CNT_W-1:0]  K_LAST = CNT_W'(K_LEN - 1);

   state_t            state, state_next;
   logic              stb_q, accept;
   logic [31:0]       a, b, sum_reg, result, acc_out_r;
   logic              acc_stb_r, ovf_r;
   logic [CNT_W-1:0]  count;
   logic              a_s, b_s, z_s;
   logic signed [9:0] a_e, b_e, z_e;
   logic [26:0]       a_m, b_m, a_den_m, b_den_m;
   logic [27:0]       sum_m;
   logic [23:0]       z_m;
   logic [24:0]       m_inc;
   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, is_special;
   logic              round_up, pack_denorm;
   logic signed [9:0] e_diff_ab, e_diff_ba;

   assign accept = bus.in_z_stb & ~stb_q;

`ifdef FPACC_FTZ_EN
   assign a_den_m = '0;
   assign b_den_m = '0;
`else
   assign a_den_m = {1'b0, a[22:0], 3'b000};
   assign b_den_m = {1'b0, b[22:0], 3'b000};
`endif

   // Unpacked operand classification; exponent 128 is the inf/NaN encoding.
   assign a_nan      = (a_e == 10'sd128) && (a_m[25:3] != 23'd0);
   assign b_nan      = (b_e == 10'sd128) && (b_m[25:3] != 23'd0);
   assign a_inf      = (a_e == 10'sd128) && (a_m[25:3] == 23'd0);
   assign b_inf      = (b_e == 10'sd128) && (b_m[25:3] == 23'd0);
   assign a_zero     = (a_m == 27'd0);
   assign b_zero     = (b_m == 27'd0);
   assign is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

   assign e_diff_ab   = a_e - b_e;
   assign e_diff_ba   = b_e - a_e;
   assign round_up    = sum_m[2] & (sum_m[1] | sum_m[0] | sum_m[3]);
   assign m_inc       = {1'b0, sum_m[26:3]} + 25'd1;
   assign pack_denorm = (z_e == EMIN) && !z_m[23];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (accept) state_next = UNPACK;
         UNPACK:  state_next = SPECIAL;
         SPECIAL: state_next = is_special ? COMMIT : ALIGN;
         ALIGN:   if (a_e == b_e) state_next = ADD;
         ADD:     state_next = NORM_1;
`ifdef FPACC_FTZ_EN
         NORM_1:  if (sum_m[27] || sum_m[26] || !(z_e > EMIN)) state_next = ROUND;
`else
         NORM_1:  if (sum_m[27] || sum_m[26] || !(z_e > EMIN)) state_next = NORM_2;
`endif
         NORM_2:  if (!(z_e < EMIN)) state_next = ROUND;
         ROUND:   state_next = PACK;
         PACK:    state_next = COMMIT;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (bus.clear) state_next = IDLE;
   end

   always_comb begin
      bus.busy        = (state != IDLE);
      bus.in_ready    = (state == IDLE);
      bus.acc_out     = acc_out_r;
      bus.acc_out_stb = acc_stb_r;
      bus.ovf_err     = ovf_r;
   end

   // Datapath: every arithmetic step is a single register update in its state.
   always_ff @(posedge clk) begin
      if (rst) begin
         stb_q <= 1'b0;   a <= '0;       b <= '0;
         sum_reg <= '0;   result <= '0;  acc_out_r <= '0;
         acc_stb_r <= 1'b0; ovf_r <= 1'b0; count <= '0;
         a_s <= 1'b0; b_s <= 1'b0; z_s <= 1'b0;
         a_e <= '0; b_e <= '0; z_e <= '0;
         a_m <= '0; b_m <= '0; sum_m <= '0; z_m <= '0;
      end else begin
         stb_q     <= bus.in_z_stb;
         acc_stb_r <= 1'b0;
         if (bus.clear) begin
            sum_reg <= '0;
            count   <= '0;
            ovf_r   <= 1'b0;
         end else begin
            if (accept && state != IDLE) ovf_r <= 1'b1;
            unique case (state)
               IDLE: if (accept) begin
                  a <= sum_reg;
                  b <= bus.in_z;
               end
               UNPACK: begin
                  a_s <= a[31];
                  b_s <= b[31];
                  if (a[30:23] == 8'd0) begin a_e <= EMIN; a_m <= a_den_m; end
                  else begin a_e <= $signed({2'b00, a[30:23]}) - 10'sd127; a_m <= {1'b1, a[22:0], 3'b000}; end
                  if (b[30:23] == 8'd0) begin b_e <= EMIN; b_m <= b_den_m; end
                  else begin b_e <= $signed({2'b00, b[30:23]}) - 10'sd127; b_m <= {1'b1, b[22:0], 3'b000}; end
               end
               SPECIAL: begin
                  if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) result <= 32'hFFC0_0000;
                  else if (a_inf)             result <= {a_s, 8'hFF, 23'd0};
                  else if (b_inf)             result <= {b_s, 8'hFF, 23'd0};
                  else if (a_zero && b_zero)  result <= {a_s & b_s, 31'd0};
                  else if (a_zero)            result <= b;
                  else if (b_zero)            result <= a;
               end
               ALIGN: begin
                  if (e_diff_ab > 10'sd27) begin
                     b_m <= {26'd0, |b_m};
                     b_e <= a_e;
                  end else if (e_diff_ba > 10'sd27) begin
                     a_m <= {26'd0, |a_m};
                     a_e <= b_e;
                  end else if (a_e > b_e) begin
                     b_m <= {1'b0, b_m[26:2], b_m[1] | b_m[0]};
                     b_e <= b_e + 10'sd1;
                  end else if (b_e > a_e) begin
                     a_m <= {1'b0, a_m[26:2], a_m[1] | a_m[0]};
                     a_e <= a_e + 10'sd1;
                  end
               end
               ADD: begin
                  z_e <= a_e;
                  if (a_s == b_s) begin
                     sum_m <= {1'b0, a_m} + {1'b0, b_m};
                     z_s   <= a_s;
                  end else if (a_m >= b_m) begin
                     sum_m <= {1'b0, a_m} - {1'b0, b_m};
                     z_s   <= (a_m == b_m) ? 1'b0 : a_s;
                  end else begin
                     sum_m <= {1'b0, b_m} - {1'b0, a_m};
                     z_s   <= b_s;
                  end
               end
               NORM_1: begin
                  if (sum_m[27]) begin
                     sum_m <= {1'b0, sum_m[27:2], sum_m[1] | sum_m[0]};
                     z_e   <= z_e + 10'sd1;
                  end else if (!sum_m[26] && z_e > EMIN) begin
                     sum_m <= {sum_m[26:0], 1'b0};
                     z_e   <= z_e - 10'sd1;
                  end
               end
               NORM_2: if (z_e < EMIN) begin
                  sum_m <= {1'b0, sum_m[27:2], sum_m[1] | sum_m[0]};
                  z_e   <= z_e + 10'sd1;
               end
               ROUND: begin
                  if (round_up && m_inc[24]) begin
                     z_m <= 24'h80_0000;
                     z_e <= z_e + 10'sd1;
                  end else if (round_up) z_m <= m_inc[23:0];
                  else                   z_m <= sum_m[26:3];
               end
               PACK: begin
                  if (z_e > EMAX)       result <= {z_s, 8'hFF, 23'd0};
`ifdef FPACC_FTZ_EN
                  else if (pack_denorm) result <= {z_s, 31'd0};
`else
                  else if (pack_denorm) result <= {z_s, 8'd0, z_m[22:0]};
`endif
                  else                  result <= {z_s, z_e[7:0] + 8'd127, z_m[22:0]};
               end
               COMMIT: begin
                  if (count == K_LAST) begin
                     acc_out_r <= result;
                     acc_stb_r <= 1'b1;
                     sum_reg   <= '0;
                     count     <= '0;
                  end else begin
                     sum_reg <= result;
                     count   <= count + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
